// File: rtl/shift_pkg.sv
// Shared types for the sequential shift/rotate unit: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [2:0] {
    LSL = 3'd0,
    LSR = 3'd1,
    ASR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate of the work value; codes outside LSL..ROR pass the value through.
// Purely combinational; o_out is the bit that leaves the word on this step.
module shift_step
  import shift_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0] i_work,
  input  logic [2:0]   i_dir,
  output logic [n-1:0] o_res,
  output logic         o_out
);

  always_comb begin
    o_res = i_work;
    o_out = 1'b0;
    case (i_dir)
      LSL: begin
        o_res = {i_work[n-2:0], 1'b0};
        o_out = i_work[n-1];
      end
      LSR: begin
        o_res = {1'b0, i_work[n-1:1]};
        o_out = i_work[0];
      end
      ASR: begin
        o_res = {i_work[n-1], i_work[n-1:1]};
        o_out = i_work[0];
      end
      ROL: begin
        o_res = {i_work[n-2:0], i_work[n-1]};
        o_out = i_work[n-1];
      end
      ROR: begin
        o_res = {i_work[0], i_work[n-1:1]};
        o_out = i_work[0];
      end
      default: begin
        o_res = i_work;
        o_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative shift/rotate: one position per clock, done pulse k+1 cycles after start.
// Starts arriving while busy (including the done cycle) are dropped, never queued.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int n  = 4,
  parameter int sw = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [n-1:0]  data,
  input  logic [sw-1:0] shift,
  input  logic [2:0]    direccion,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  y,
  output logic          carry,
  output logic          zero
);

  state_t        r_state;
  logic [n-1:0]  r_work;
  logic [sw-1:0] r_cnt;
  logic [2:0]    r_dir;
  logic          r_cwork;
  logic          r_busy;
  logic          r_done;
  logic [n-1:0]  r_y;
  logic          r_carry;
  logic          r_zero;

  logic [n-1:0]  w_step_res;
  logic          w_step_out;
  logic          w_no_steps;

  shift_step #(.n(n)) u_step (
    .i_work (r_work),
    .i_dir  (r_dir),
    .o_res  (w_step_res),
    .o_out  (w_step_out)
  );

  // Zero amount or a pass-through code skips SHIFT and goes straight to DONE.
  assign w_no_steps = (shift == '0) || (direccion > 3'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_dir   <= '0;
      r_cwork <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work  <= data;
            r_cnt   <= shift;
            r_dir   <= direccion;
            r_cwork <= 1'b0;
            r_busy  <= 1'b1;
            if (w_no_steps) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_y     <= data;
              r_carry <= 1'b0;
              r_zero  <= (data == '0);
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work  <= w_step_res;
          r_cwork <= w_step_out;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == sw'(1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_y     <= w_step_res;
            r_carry <= w_step_out;
            r_zero  <= (w_step_res == '0);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign y     = r_y;
  assign carry = r_carry;
  assign zero  = r_zero;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed and random operations against an arithmetic reference of shift/rotate results.
module tb_seq_shift_unit;

  localparam int N  = 4;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  data;
  logic [SW-1:0] shift;
  logic [2:0]    direccion;
  logic          busy;
  logic          done;
  logic [N-1:0]  y;
  logic          carry;
  logic          zero;

  int checks = 0;
  int errors = 0;

  seq_shift_unit #(.n(N), .sw(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .shift     (shift),
    .direccion (direccion),
    .busy      (busy),
    .done      (done),
    .y         (y),
    .carry     (carry),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form result of shifting d by k positions, derived from the operation rules.
  task automatic ref_model(input int d, input int k, input int dir, output int ry, output int rc);
    int mask, sd, r;
    mask = (1 << N) - 1;
    ry = d;
    rc = 0;
    if (k != 0 && dir < 5) begin
      r = k % N;
      case (dir)
        0: begin
          ry = (d << k) & mask;
          rc = (k > N) ? 0 : (d >> (N - k)) & 1;
        end
        1: begin
          ry = d >> k;
          rc = (k > N) ? 0 : (d >> (k - 1)) & 1;
        end
        2: begin
          sd = ((d >> (N - 1)) & 1) ? d - (1 << N) : d;
          ry = (sd >>> k) & mask;
          rc = (d >> (((k < N) ? k : N) - 1)) & 1;
        end
        3: begin
          ry = ((d << r) | (d >> (N - r))) & mask;
          rc = ry & 1;
        end
        default: begin
          ry = ((d >> r) | (d << (N - r))) & mask;
          rc = (ry >> (N - 1)) & 1;
        end
      endcase
    end
  endtask

  task automatic run_op(input int d, input int k, input int dir, input int poke, input string tag);
    int exp_y, exp_c, exp_cyc, cyc, done_cyc;
    logic [N-1:0] y_prev;
    logic c_prev, z_prev;
    ref_model(d, k, dir, exp_y, exp_c);
    exp_cyc = (k == 0 || dir >= 5) ? 1 : k + 1;
    @(negedge clk);
    chk({tag, " idle_busy"}, busy, 0);
    y_prev = y;
    c_prev = carry;
    z_prev = zero;
    start = 1'b1;
    data = N'(d);
    shift = SW'(k);
    direccion = 3'(dir);
    @(posedge clk); #1;
    start = 1'b0;
    data = N'($urandom);
    shift = SW'($urandom);
    direccion = 3'($urandom);
    cyc = 1;
    done_cyc = 0;
    while (done_cyc == 0 && cyc <= 12) begin
      chk({tag, " busy"}, busy, 1);
      if (done) begin
        done_cyc = cyc;
      end else begin
        chk({tag, " hold"}, {y, carry, zero}, {y_prev, c_prev, z_prev});
        start = (cyc == poke);
        data = N'($urandom);
        shift = SW'($urandom);
        direccion = 3'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, " done_cycle"}, done_cyc, exp_cyc);
    chk({tag, " y"}, y, exp_y);
    chk({tag, " carry"}, carry, exp_c);
    chk({tag, " zero"}, zero, (exp_y == 0));
    // A start during the done cycle must be dropped.
    start = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " post_done"}, done, 0);
    chk({tag, " post_busy"}, busy, 0);
    chk({tag, " post_y"}, y, exp_y);
  endtask

  initial begin
    int saw_done;
    rst = 1'b0;
    start = 1'b0;
    data = '0;
    shift = '0;
    direccion = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst y", y, 0);
    chk("rst carry", carry, 0);
    chk("rst zero", zero, 1);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'b1100, 2, 0, 0, "lsl");
    chk("lsl lit y", y, 4'b0000);
    chk("lsl lit carry", carry, 1);
    chk("lsl lit zero", zero, 1);

    run_op(4'b1101, 1, 2, 0, "asr");
    chk("asr lit y", y, 4'b1110);
    chk("asr lit carry", carry, 1);
    chk("asr lit zero", zero, 0);

    run_op(4'b1101, 2, 4, 0, "ror");
    chk("ror lit y", y, 4'b0111);
    chk("ror lit carry", carry, 0);

    run_op(4'b1101, 7, 3, 0, "rol7");
    chk("rol7 lit y", y, 4'b1110);
    chk("rol7 lit carry", carry, 0);

    run_op(4'b1011, 0, 0, 0, "k0");
    chk("k0 lit y", y, 4'b1011);
    run_op(4'b1011, 3, 6, 0, "pass");
    chk("pass lit y", y, 4'b1011);
    chk("pass lit carry", carry, 0);

    run_op(4'b1000, 5, 1, 2, "lsr_ignore");
    chk("lsr_ignore lit y", y, 4'b0000);
    chk("lsr_ignore lit carry", carry, 0);

    // Abort mid-operation with reset.
    @(negedge clk);
    start = 1'b1;
    data = 4'b1000;
    shift = 3'd5;
    direccion = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort y", y, 0);
    chk("abort carry", carry, 0);
    chk("abort zero", zero, 1);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("abort no_done", saw_done, 0);
    run_op(4'b0011, 1, 0, 0, "after_abort");
    chk("after_abort lit y", y, 4'b0110);
    chk("after_abort lit carry", carry, 0);

    for (int t = 0; t < 60; t++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle, one-bit-per-clock shift/rotate unit for the lab 3 ALU datapath. It sits between the ALU operand registers and the ALU result mux. It accepts a start request with operand, amount and direction, then iterates one position per cycle. It presents a registered result with carry and zero flags, signalled by a one-cycle `done` pulse. It produces the same results as the combinational `Shifts` path, plus registered carry and zero flags.

## Interface
- `n`, default 4: data width.
- `sw`, default 3: shift-amount width; maximum amount is 2^sw-1.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `start`  in  1: request; sampled only in IDLE.
- `data`  in  n: operand, captured on accepted start.
- `shift`  in  sw: shift amount, captured on accepted start.
- `direccion`  in  3: operation, captured on accepted start. 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 pass-through.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; `y`, `carry` and `zero` are valid from this cycle onward.
- `y`  out  n: result register; holds its value until the next `done`.
- `carry`  out  1: last bit shifted or rotated out; 0 if no step was taken.
- `zero`  out  1: high when `y` is 0.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - `start`=1 latches `data` into the work register and `shift` into the down-counter `cnt`.
  - It also latches the direction and clears the carry register.
  - Next state is DONE if the latched amount is 0 or the direction is 5-7; otherwise SHIFT.
- SHIFT, each cycle:
  - Apply one step to the work register.
  - Carry register takes the bit leaving the word: bit n-1 for LSL/ROL, bit 0 for LSR/ASR/ROR.
  - `cnt` decrements by 1; when `cnt` was 1, next state is DONE.
- Step rules:
  - LSL fills bit 0 with 0.
  - LSR fills bit n-1 with 0.
  - ASR replicates bit n-1.
  - ROL/ROR feed the outgoing bit back in at the opposite end.
- Amounts ≥ n are iterated literally, never clamped:
  - LSL/LSR produce 0.
  - ASR produces all sign bits.
  - Rotates wrap modulo n.
- On the edge entering DONE, `y`, `carry` and `zero` load from the work register and carry register.
- DONE: `done`=1 for one cycle, then unconditionally return to IDLE.
- `start` while `busy`=1, including in DONE, is ignored and not queued.
- Inputs may change after acceptance without affecting the operation in flight.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `y` 0, `carry` 0, `zero` 1, `cnt` 0.
- `rst` asserted mid-operation aborts immediately:
  - No `done` pulse is produced.
  - Outputs take their reset values.
- With start sampled at edge 0 and amount k:
  - `done` is high in cycle k+1, i.e. after edge k.
  - Pass-through or k=0 gives `done` in cycle 1.
- Throughput: a new start can be accepted in the first cycle with `done`=0 after the pulse, i.e. k+2 cycles per operation.
- `busy` rises the cycle after the accepting edge and falls together with `done`.
- `y`, `carry` and `zero` change only on the edge that enters DONE, or on reset.

## Structure
- Package `shift_pkg` holds:
  - `typedef enum logic [2:0] shift_dir_t`: LSL=0, LSR=1, ASR=2, ROL=3, ROR=4.
  - `typedef enum logic [1:0] state_t`: IDLE, SHIFT, DONE.
- Sub-module `shift_step` is combinational and parameterized by `n`:
  - Inputs: work value and direction.
  - Outputs: the one-position result and the outgoing bit.
  - It is instantiated once in `seq_shift_unit`.
- Top level contains the FSM, the counter and the output registers.

## Test plan
- LSL, `data`=1100, `shift`=2 -> `y`=0000, `carry`=1, `zero`=1; `done` in cycle 3; `busy` high in cycles 1-3.
- ASR, `data`=1101, `shift`=1 -> `y`=1110, `carry`=1, `zero`=0; `done` in cycle 2.
- ROR, `data`=1101, `shift`=2 -> `y`=0111, `carry`=0. ROL, `data`=1101, `shift`=7 -> `y`=1110, `carry`=0; `done` in cycle 8.
- `shift`=0, or `direccion`=6, with `data`=1011 -> `y`=1011, `carry`=0; `done` in cycle 1.
- LSR, `data`=1000, `shift`=5; a second `start` in cycle 2 is ignored. Expected: one `done` only, in cycle 6, with `y`=0000 and `carry`=0.
- LSR, `data`=1000, `shift`=5; `rst` pulsed in cycle 2 -> `busy`=0, `y`=0000, `zero`=1, no `done`. A following LSL, `data`=0011, `shift`=1 -> `y`=0110, `carry`=0.
